// File: rtl/mips_pkg.sv
// Shared MIPS core types: word width, NOP encoding and the instruction-memory
// response payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] data;
  } imem_rsp_t;

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// Synchronous response FIFO of {err, data}; registered storage, no fall-through.
module resp_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  imem_rsp_t        push_data,
  input  logic             pop,
  output imem_rsp_t        pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_rsp_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/imem_responder.sv
// Word-addressed instruction store answering in-order fetches after a fixed
// latency, with credit-based flow control so no response is ever dropped.
module imem_responder
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [WORD_W-1:0] i_req_addr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [WORD_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [WORD_W-1:0] i_ld_data
);

  localparam int unsigned STORE_WORDS = 1 << ADDR_W;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] store [STORE_WORDS];
  logic              accept;
  logic              pop;
  logic              out_of_range;
  imem_rsp_t         rd_rsp;
  imem_rsp_t         push_rsp;
  imem_rsp_t         head_rsp;
  logic              push_vld;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic              unused_fifo;

  assign accept       = i_req_valid & o_req_ready;
  assign pop          = o_rsp_valid & i_rsp_ready;
  assign out_of_range = |i_req_addr[WORD_W-1:ADDR_W];

  // Load port; the array is read combinationally, so a same-cycle fetch sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_ld_en) store[i_ld_addr] <= i_ld_data;
  end

  always_comb begin
    rd_rsp.err  = out_of_range;
    rd_rsp.data = out_of_range ? INSTR_NOP : store[i_req_addr[ADDR_W-1:0]];
  end

  // Delay line: LATENCY-1 register stages between the store read and the FIFO push.
  generate
    if (LATENCY <= 1) begin : g_direct
      assign push_vld = accept;
      assign push_rsp = rd_rsp;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      imem_rsp_t          rsp_q [LATENCY-1];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < int'(LATENCY - 1); i++) rsp_q[i] <= '0;
        end else begin
          vld_q[0] <= accept;
          rsp_q[0] <= rd_rsp;
          for (int i = 1; i < int'(LATENCY - 1); i++) begin
            vld_q[i] <= vld_q[i-1];
            rsp_q[i] <= rsp_q[i-1];
          end
        end
      end

      assign push_vld = vld_q[LATENCY-2];
      assign push_rsp = rsp_q[LATENCY-2];
    end
  endgenerate

  resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push_vld),
    .push_data (push_rsp),
    .pop       (pop),
    .pop_data  (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_fifo = ^{fifo_full, fifo_count};

  // Credits cover both the delay line and the FIFO, so the FIFO can never overflow.
  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding <= '0;
      o_req_ready <= 1'b1;
    end else begin
      outstanding <= outstanding_nxt;
      o_req_ready <= (outstanding_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

  assign o_rsp_valid = ~fifo_empty;
  assign o_rsp_data  = head_rsp.data;
  assign o_rsp_err   = head_rsp.err;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed fetch scenarios on a LATENCY=1/DEPTH=2
// instance and a randomized run on a LATENCY=3/DEPTH=4 instance.
module tb_imem_responder;

  localparam int NI   = 2;
  localparam int RING = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic [31:0] req_addr  [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_data  [NI];
  logic        rsp_err   [NI];
  logic        ld_en     [NI];
  logic [7:0]  ld_addr   [NI];
  logic [31:0] ld_data   [NI];

  imem_responder #(.ADDR_W(8), .LATENCY(1), .FIFO_DEPTH(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_addr(req_addr[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0]),
    .i_ld_en(ld_en[0]), .i_ld_addr(ld_addr[0]), .i_ld_data(ld_data[0])
  );

  imem_responder #(.ADDR_W(8), .LATENCY(3), .FIFO_DEPTH(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_addr(req_addr[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1]),
    .i_ld_en(ld_en[1]), .i_ld_addr(ld_addr[1]), .i_ld_data(ld_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 32'h%08h, required 32'h%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a store image plus a list of accepted fetches with due cycles.
  logic [31:0] mem_m   [NI][256];
  logic [31:0] pd_data [NI][RING];
  logic        pd_err  [NI][RING];
  int          pd_due  [NI][RING];
  int          head    [NI] = '{default: 0};
  int          tail    [NI] = '{default: 0};
  int          nacc    [NI] = '{default: 0};
  int          dut_out [NI] = '{default: 0};
  int          cyc = 0;
  int          n_m, idx_m;
  logic        ev_m, er_m, pop_m, acc_m;

  logic [31:0] got_data [$];
  logic        got_err  [$];
  int          got_cyc  [$];
  int          acc_cyc  [$];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        chk($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
        chk($sformatf("rst_rsp_data%0d", k), rsp_data[k], 32'd0);
        chk($sformatf("rst_rsp_err%0d", k), 32'(rsp_err[k]), 32'd0);
        head[k]    = 0;
        tail[k]    = 0;
        dut_out[k] = 0;
      end else begin
        n_m  = tail[k] - head[k];
        er_m = (n_m < dep_of(k));
        ev_m = (n_m > 0) && (pd_due[k][head[k] % RING] <= cyc);
        chk($sformatf("req_ready%0d", k), 32'(req_ready[k]), 32'(er_m));
        chk($sformatf("rsp_valid%0d", k), 32'(rsp_valid[k]), 32'(ev_m));
        if (ev_m) begin
          chk($sformatf("rsp_data%0d", k), rsp_data[k], pd_data[k][head[k] % RING]);
          chk($sformatf("rsp_err%0d", k), 32'(rsp_err[k]), 32'(pd_err[k][head[k] % RING]));
        end
        pop_m = ev_m && rsp_ready[k];
        acc_m = req_valid[k] && er_m;
        if (pop_m) begin
          if (k == 0) begin
            got_data.push_back(rsp_data[k]);
            got_err.push_back(rsp_err[k]);
            got_cyc.push_back(cyc);
          end
          head[k]++;
        end
        if (acc_m) begin
          idx_m              = tail[k] % RING;
          pd_err[k][idx_m]   = (req_addr[k] > 32'd255);
          pd_data[k][idx_m]  = pd_err[k][idx_m] ? 32'h0 : mem_m[k][req_addr[k][7:0]];
          pd_due[k][idx_m]   = cyc + lat_of(k);
          tail[k]++;
          nacc[k]++;
          if (k == 0) acc_cyc.push_back(cyc);
        end
        if (ld_en[k]) mem_m[k][ld_addr[k]] = ld_data[k];
        dut_out[k] += int'(req_valid[k] && req_ready[k]) - int'(rsp_valid[k] && rsp_ready[k]);
        chk($sformatf("outstanding_bound%0d", k), 32'(dut_out[k] <= dep_of(k)), 32'd1);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one fetch on instance 0 and hold it until accepted.
  task automatic req0(input logic [31:0] a);
    int w;
    w = 0;
    req_valid[0] = 1'b1;
    req_addr[0]  = a;
    @(negedge clk);
    while (!req_ready[0] && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) chk("req0_accept_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] d, input logic e);
    if (idx < got_data.size()) begin
      chk({name, "_data"}, got_data[idx], d);
      chk({name, "_err"}, 32'(got_err[idx]), 32'(e));
    end else begin
      chk({name, "_present"}, 32'(got_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int a;
    int w;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = 32'h0;
      rsp_ready[k] = 1'b1;
      ld_en[k]     = 1'b0;
      ld_addr[k]   = 8'h0;
      ld_data[k]   = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t0_ready_after_release", 32'(req_ready[0]), 32'd1);
    chk("t0_valid_after_release", 32'(rsp_valid[0]), 32'd0);
    step;

    // Fill both stores through the load port.
    for (int i = 0; i < 256; i++) begin
      ld_en[0]   = 1'b1;
      ld_addr[0] = 8'(i);
      ld_data[0] = (i < 4) ? 32'h2001_0001 + 32'(i) : 32'h0;
      ld_en[1]   = 1'b1;
      ld_addr[1] = 8'(i);
      ld_data[1] = $urandom;
      step;
    end
    ld_en[0] = 1'b0;
    ld_en[1] = 1'b0;
    step;

    // Back-to-back fetches with a free-running consumer.
    g = got_data.size();
    a = acc_cyc.size();
    for (int i = 0; i < 4; i++) req0(32'(i));
    repeat (4) step;
    for (int i = 0; i < 4; i++) chk_got("t1_word", g + i, 32'h2001_0001 + 32'(i), 1'b0);
    if (got_cyc.size() > g && acc_cyc.size() > a + 3) begin
      chk("t1_first_latency", 32'(got_cyc[g] - acc_cyc[a]), 32'd1);
      chk("t1_back_to_back", 32'(acc_cyc[a+3] - acc_cyc[a]), 32'd3);
    end else begin
      chk("t1_log_size", 32'(got_cyc.size() - g), 32'd4);
    end

    // Stalled consumer: only FIFO_DEPTH requests get credit.
    g = got_data.size();
    rsp_ready[0] = 1'b0;
    req0(32'd0);
    req0(32'd1);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'd2;
    repeat (3) begin
      @(negedge clk);
      chk("t2_ready_low", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready[0] && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("t2_ready_returns", 32'(w < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (4) step;
    chk("t2_count", 32'(got_data.size() - g), 32'd3);
    chk_got("t2_w0", g, 32'h2001_0001, 1'b0);
    chk_got("t2_w1", g + 1, 32'h2001_0002, 1'b0);
    chk_got("t2_w2", g + 2, 32'h2001_0003, 1'b0);

    // Out-of-range fetch followed by a legal one.
    g = got_data.size();
    req0(32'h0000_0100);
    req0(32'd2);
    repeat (4) step;
    chk_got("t3_oor", g, 32'h0, 1'b1);
    chk_got("t3_inrange", g + 1, 32'h2001_0003, 1'b0);

    // Load and fetch of index 5 in the same cycle.
    g = got_data.size();
    ld_en[0]   = 1'b1;
    ld_addr[0] = 8'd5;
    ld_data[0] = 32'hDEAD_BEEF;
    req0(32'd5);
    ld_en[0] = 1'b0;
    req0(32'd5);
    repeat (4) step;
    chk_got("t4_old_word", g, 32'h0, 1'b0);
    chk_got("t4_new_word", g + 1, 32'hDEAD_BEEF, 1'b0);

    // Reset with two requests outstanding.
    rsp_ready[0] = 1'b0;
    req0(32'd0);
    req0(32'd1);
    chk("t5_valid_before_reset", 32'(rsp_valid[0]), 32'd1);
    g = got_data.size();
    rst_n = 1'b0;
    #1;
    chk("t5_valid_async_clear", 32'(rsp_valid[0]), 32'd0);
    repeat (2) step;
    rsp_ready[0] = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after_release", 32'(req_ready[0]), 32'd1);
    repeat (10) step;
    chk("t5_no_stale", 32'(got_data.size() - g), 32'd0);

    // Randomized traffic on the LATENCY=3 / FIFO_DEPTH=4 instance.
    w = 0;
    while (nacc[1] < 1000 && w < 20000) begin
      req_valid[1] = ($urandom_range(0, 3) != 0);
      req_addr[1]  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 255);
      rsp_ready[1] = ($urandom_range(0, 2) != 0);
      ld_en[1]     = ($urandom_range(0, 7) == 0);
      ld_addr[1]   = 8'($urandom_range(0, 255));
      ld_data[1]   = $urandom;
      step;
      w++;
    end
    req_valid[1] = 1'b0;
    ld_en[1]     = 1'b0;
    rsp_ready[1] = 1'b1;
    w = 0;
    while (head[1] != tail[1] && w < 100) begin
      step;
      w++;
    end
    repeat (2) step;
    chk("t6_accepted", 32'(nacc[1]), 32'd1000);
    chk("t6_model_drained", 32'(tail[1] - head[1]), 32'd0);
    chk("t6_dut_drained", 32'(dut_out[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
